emmc_pattern_tester: RTL and testbench

- Parametrised write/read-back traffic engine that sits on the host-side interface of emmc_sm, alongside the card-facing pads in the test core.
- Writes a regenerable data pattern to a group of blocks, reads the same group back and compares every byte, then advances through the configured block range.
- Generalises the fixed checkerboard/2-block test: selectable pattern mode and seed, a partial last group, saturating error counter, first-error location capture, stop request and fault detection.

---
 rtl/emmc_pattern_tester_pkg.sv | 11 +
 rtl/emmc_pattern_tester_if.sv | 17 +
 rtl/emmc_pattern_tester_gen.sv | 30 +++
 rtl/emmc_pattern_tester.sv | 159 +++++++++++++++
 tb/tb_emmc_pattern_tester.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/emmc_pattern_tester_pkg.sv
// emmc_tester_p: shared types and constants for the eMMC pattern tester
package emmc_tester_p;
  typedef enum logic [1:0] {PAT_CHECKER, PAT_INCR, PAT_LFSR} pat_e;
  typedef enum logic [2:0] {S_IDLE, S_WAIT_RDY, S_WRITE, S_READ, S_NEXT, S_DONE, S_FAULT} state_e;
  localparam logic [7:0] LFSR_POLY = 8'hB8;
  localparam logic [7:0] CHK_A = 8'h55;
  localparam logic [7:0] CHK_B = 8'hAA;
  function automatic logic [7:0] lfsr_next(input logic [7:0] x);
    return x[0] ? (x >> 1) ^ LFSR_POLY : x >> 1;
  endfunction
endpackage

// File: rtl/emmc_pattern_tester_if.sv
// emmc_pattern_tester_if: host-side transfer bus between the tester and emmc_sm
interface emmc_pattern_tester_if #(
  parameter int BLK_CNT = 2,
  parameter int IDX_W   = 32
) ();
  localparam int CNT_W = $clog2(BLK_CNT + 1);
  logic             ready;
  logic             dvalid;
  logic [7:0]       rdat;
  logic [7:0]       wdat;
  logic             start;
  logic             we;
  logic [CNT_W-1:0] blk_cnt;
  logic [IDX_W-1:0] blk_idx;
  modport master (input ready, dvalid, rdat, output wdat, start, we, blk_cnt, blk_idx);
  modport slave (output ready, dvalid, rdat, input wdat, start, we, blk_cnt, blk_idx);
endinterface

// File: rtl/emmc_pattern_tester_gen.sv
// emmc_pattern_gen: per-beat pattern byte; checkerboard, incrementing or per-block reseeded LFSR
module emmc_pattern_gen
  import emmc_tester_p::*;
#(
  parameter int OFF_W = 9
) (
  input  logic             clk_core,
  input  logic             rst_tk,
  input  logic [1:0]       mode_i,
  input  logic [7:0]       seed_i,
  input  logic [7:0]       blk_i,
  input  logic [OFF_W-1:0] off_i,
  input  logic             reseed_i,
  input  logic             step_i,
  output logic [7:0]       dat_o
);
  logic [7:0] lfsr_q, s0, cur, off8;
  always_comb begin
    off8 = 8'(off_i);
    s0 = (seed_i ^ blk_i) == 8'h00 ? 8'h01 : seed_i ^ blk_i;
    // offset 0 always takes the block seed, so every block restarts the sequence
    cur = off_i == '0 ? s0 : lfsr_q;
    dat_o = mode_i == PAT_INCR ? off8 + blk_i + seed_i :
            mode_i == PAT_LFSR ? cur :
            ((off_i[0] ^ blk_i[0]) ? CHK_B : CHK_A) ^ seed_i;
  end
  always_ff @(posedge clk_core or posedge rst_tk)
    if (rst_tk) lfsr_q <= '0;
    else lfsr_q <= reseed_i ? s0 : step_i ? lfsr_next(cur) : lfsr_q;
endmodule

// File: rtl/emmc_pattern_tester.sv
// emmc_pattern_tester: writes a pattern to block groups, reads them back and checks every byte
module emmc_pattern_tester
  import emmc_tester_p::*;
#(
  parameter int BLK_CNT    = 2,
  parameter int BLK_BYTES  = 512,
  parameter int TOTAL_BLKS = 1562500,
  parameter int IDX_W      = 32,
  parameter int ERR_W      = 16,
  localparam int OFF_W = $clog2(BLK_BYTES),
  localparam int CNT_W = $clog2(BLK_CNT + 1),
  localparam int BC_W  = $clog2(BLK_CNT * BLK_BYTES)
) (
  input  logic                 clk_core,
  input  logic                 rst_tk,
  emmc_pattern_tester_if.master bus,
  input  logic                 run_i,
  input  logic                 stop_i,
  input  logic [1:0]           mode_i,
  input  logic [7:0]           seed_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 fault_o,
  output logic                 err_o,
  output logic [ERR_W-1:0]     err_cnt_o,
  output logic [IDX_W-1:0]     first_err_blk_o,
  output logic [OFF_W-1:0]     first_err_off_o
);
  localparam logic [IDX_W-1:0] TOTAL = IDX_W'(TOTAL_BLKS);
  state_e state_q, state_d;
  logic [1:0] mode_q, mode_d;
  logic [7:0] seed_q, seed_d, pat;
  logic stop_q, stop_d, err_q, err_d;
  logic we_q, start_q, busy_q, done_q, fault_q;
  logic [IDX_W-1:0] idx_q, idx_d, feb_q, feb_d, blk, rem;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [BC_W-1:0] bc_q, bc_d;
  logic [OFF_W-1:0] feo_q, feo_d, off;
  logic [ERR_W-1:0] ecnt_q, ecnt_d;
  logic [CNT_W+OFF_W-1:0] beats;
  logic last, beat, reseed;
  assign beats = {cnt_q, {OFF_W{1'b0}}};
  assign last = bc_q == BC_W'(beats - 1'b1);
  assign blk = idx_q + IDX_W'(bc_q >> OFF_W);
  assign off = bc_q[OFF_W-1:0];
  assign beat = bus.dvalid && (state_q == S_WRITE || state_q == S_READ);
  always_comb begin
    state_d = state_q;
    mode_d = mode_q;
    seed_d = seed_q;
    idx_d = idx_q;
    bc_d = bc_q;
    err_d = err_q;
    ecnt_d = ecnt_q;
    feb_d = feb_q;
    feo_d = feo_q;
    case (state_q)
      S_IDLE: if (run_i) begin
        state_d = S_WAIT_RDY;
        mode_d = mode_i;
        seed_d = seed_i;
        idx_d = '0;
        err_d = 1'b0;
        ecnt_d = '0;
        feb_d = '0;
        feo_d = '0;
      end
      S_WAIT_RDY: if (bus.ready) state_d = S_WRITE;
      S_WRITE: if (!bus.ready) state_d = S_FAULT;
        else if (beat) begin
          bc_d = last ? '0 : bc_q + 1'b1;
          state_d = last ? S_READ : S_WRITE;
        end
      S_READ: if (!bus.ready) state_d = S_FAULT;
        else if (beat) begin
          bc_d = last ? '0 : bc_q + 1'b1;
          state_d = last ? S_NEXT : S_READ;
          if (bus.rdat != pat) begin
            ecnt_d = &ecnt_q ? ecnt_q : ecnt_q + 1'b1;
            err_d = 1'b1;
            feb_d = err_q ? feb_q : blk;
            feo_d = err_q ? feo_q : off;
          end
        end
      S_NEXT: if (!bus.ready) state_d = S_FAULT;
        else begin
          idx_d = idx_q + IDX_W'(cnt_q);
          state_d = (idx_d >= TOTAL || stop_q || stop_i) ? S_DONE : S_WRITE;
        end
      S_DONE: if (!run_i) state_d = S_IDLE;
      default: state_d = state_q;
    endcase
    stop_d = state_q == S_IDLE ? 1'b0 : stop_q | (stop_i & busy_q);
    rem = TOTAL - idx_d;
    cnt_d = (state_d == S_WRITE && state_q != S_WRITE) ?
            (rem < IDX_W'(BLK_CNT) ? CNT_W'(rem) : CNT_W'(BLK_CNT)) : cnt_q;
    reseed = state_d != state_q && (state_d == S_WRITE || state_d == S_READ);
  end
  // status flags are registered from the next state so they line up with state_q
  always_ff @(posedge clk_core or posedge rst_tk)
    if (rst_tk) begin
      state_q <= S_IDLE;
      mode_q <= '0;
      seed_q <= '0;
      stop_q <= 1'b0;
      idx_q <= '0;
      cnt_q <= '0;
      bc_q <= '0;
      err_q <= 1'b0;
      ecnt_q <= '0;
      feb_q <= '0;
      feo_q <= '0;
      we_q <= 1'b0;
      start_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      seed_q <= seed_d;
      stop_q <= stop_d;
      idx_q <= idx_d;
      cnt_q <= cnt_d;
      bc_q <= bc_d;
      err_q <= err_d;
      ecnt_q <= ecnt_d;
      feb_q <= feb_d;
      feo_q <= feo_d;
      we_q <= state_d == S_WRITE;
      start_q <= state_d inside {S_WRITE, S_READ};
      busy_q <= state_d inside {S_WAIT_RDY, S_WRITE, S_READ, S_NEXT};
      done_q <= state_d == S_DONE;
      fault_q <= state_d == S_FAULT;
    end
  emmc_pattern_gen #(.OFF_W(OFF_W)) u_gen (
    .clk_core(clk_core),
    .rst_tk(rst_tk),
    .mode_i(mode_q),
    .seed_i(seed_q),
    .blk_i(blk[7:0]),
    .off_i(off),
    .reseed_i(reseed),
    .step_i(beat),
    .dat_o(pat)
  );
  assign bus.wdat = we_q ? pat : 8'h00;
  assign bus.we = we_q;
  assign bus.start = start_q;
  assign bus.blk_cnt = cnt_q;
  assign bus.blk_idx = idx_q;
  assign busy_o = busy_q;
  assign done_o = done_q;
  assign fault_o = fault_q;
  assign err_o = err_q;
  assign err_cnt_o = ecnt_q;
  assign first_err_blk_o = feb_q;
  assign first_err_off_o = feo_q;
endmodule

// File: tb/tb_emmc_pattern_tester.sv
// tb_emmc_pattern_tester: directed runs against an echoing emmc_sm byte-memory model
module tb_emmc_pattern_tester;
  logic clk = 1'b0, rst = 1'b1, run = 1'b0, stop = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] seed = 8'd0;
  logic busy, done, fault, err;
  logic [3:0] ecnt;
  logic [31:0] feb;
  logic [8:0] feo;
  int n_cmp = 0, n_bad = 0;
  logic [7:0] mem [0:2559];
  int pos = 0, ph = 0, wr_n = 0, rd_n = 0, g_n = 0, cm = 0;
  int g_idx [8], g_cnt [8];
  logic prev_start = 1'b0;

  emmc_pattern_tester_if #(.BLK_CNT(2), .IDX_W(32)) bus ();

  emmc_pattern_tester #(.BLK_CNT(2), .BLK_BYTES(512), .TOTAL_BLKS(5), .IDX_W(32), .ERR_W(4)) dut (
    .clk_core(clk), .rst_tk(rst), .bus(bus), .run_i(run), .stop_i(stop), .mode_i(mode),
    .seed_i(seed), .busy_o(busy), .done_o(done), .fault_o(fault), .err_o(err),
    .err_cnt_o(ecnt), .first_err_blk_o(feb), .first_err_off_o(feo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !done; i++) @(negedge clk);
    chk("done_reached", done, 1);
  endtask

  // emmc_sm stand-in: a beat every 3rd cycle while start is high, echoing written bytes
  initial begin
    bus.dvalid = 1'b0;
    bus.rdat = 8'h00;
    forever begin
      @(negedge clk);
      bus.dvalid = 1'b0;
      if (rst) begin pos = 0; ph = 0; end
      if (!run) begin wr_n = 0; rd_n = 0; g_n = 0; end
      if (bus.start && !prev_start && g_n < 8) begin
        g_idx[g_n] = int'(bus.blk_idx);
        g_cnt[g_n] = int'(bus.blk_cnt);
        g_n++;
      end
      prev_start = bus.start;
      if (!bus.start) ph = 0;
      else begin
        ph = ph + 1;
        if (ph == 3) begin
          int a;
          logic [7:0] d;
          ph = 0;
          a = int'(bus.blk_idx) * 512 + pos;
          bus.dvalid = 1'b1;
          if (bus.we) begin
            mem[a] = bus.wdat;
            wr_n++;
          end else begin
            d = mem[a];
            if (cm == 2) d = ~d;
            if (cm == 1 && (a == 3 * 512 + 17 || a == 4 * 512)) d ^= 8'h01;
            bus.rdat = d;
            rd_n++;
          end
          pos = (pos == int'(bus.blk_cnt) * 512 - 1) ? 0 : pos + 1;
        end
      end
    end
  end

  initial begin
    bus.ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_busy", busy, 0);
    chk("rst_start", bus.start, 0);
    chk("rst_wdat", bus.wdat, 0);
    chk("rst_ecnt", ecnt, 0);
    rst = 1'b0;

    // run A: mode 0, full range of 5 blocks, ready after 20 cycles
    mode = 2'd0; seed = 8'h00; run = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("wait_busy", busy, 1);
    chk("wait_start", bus.start, 0);
    repeat (18) @(negedge clk);
    bus.ready = 1'b1;
    wait_done(20000);
    chk("a_wr_beats", wr_n, 2560);
    chk("a_rd_beats", rd_n, 2560);
    chk("a_groups", g_n, 3);
    chk("a_g0_idx", g_idx[0], 0);
    chk("a_g1_idx", g_idx[1], 2);
    chk("a_g2_idx", g_idx[2], 4);
    chk("a_g1_cnt", g_cnt[1], 2);
    chk("a_g2_cnt", g_cnt[2], 1);
    chk("a_final_idx", bus.blk_idx, 5);
    chk("a_busy", busy, 0);
    chk("a_err", err, 0);
    chk("a_ecnt", ecnt, 0);
    chk("a_b0o0", mem[0], 8'h55);
    chk("a_b0o1", mem[1], 8'hAA);
    chk("a_b1o0", mem[512], 8'hAA);
    run = 1'b0;
    repeat (2) @(negedge clk);

    // run B: LFSR, two corrupted read bytes
    cm = 1; mode = 2'd2; seed = 8'h3C; run = 1'b1;
    wait_done(20000);
    chk("b_ecnt", ecnt, 2);
    chk("b_err", err, 1);
    chk("b_feb", feb, 3);
    chk("b_feo", feo, 17);
    chk("b_lfsr0", mem[0], 8'h3C);
    chk("b_lfsr1", mem[1], 8'h1E);
    chk("b_lfsr2", mem[2], 8'h0F);
    chk("b_lfsr3", mem[3], 8'hBF);
    chk("b_b1o1", mem[513], 8'hA6);
    chk("b_b3o0", mem[1536], 8'h3F);
    run = 1'b0;
    repeat (2) @(negedge clk);
    chk("b_idle_done", done, 0);
    chk("b_kept_ecnt", ecnt, 2);
    chk("b_kept_feb", feb, 3);

    // run C: incrementing, every read inverted, stop during group 0
    cm = 2; mode = 2'd1; seed = 8'h05; run = 1'b1;
    repeat (3) @(negedge clk);
    chk("c_clr_ecnt", ecnt, 0);
    chk("c_clr_err", err, 0);
    chk("c_clr_feb", feb, 0);
    repeat (100) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done(10000);
    chk("c_sat_ecnt", ecnt, 15);
    chk("c_err", err, 1);
    chk("c_feo", feo, 0);
    chk("c_final_idx", bus.blk_idx, 2);
    chk("c_groups", g_n, 1);
    chk("c_inc3", mem[3], 8'h08);
    chk("c_inc255", mem[767], 8'h05);
    chk("c_inc256", mem[768], 8'h06);
    run = 1'b0;
    repeat (2) @(negedge clk);

    // run D: stop mid-write of group 1
    cm = 0; mode = 2'd0; seed = 8'h00; run = 1'b1;
    for (int i = 0; i < 10000 && g_n < 2; i++) @(negedge clk);
    chk("d_in_write", bus.we, 1);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done(16000);
    chk("d_final_idx", bus.blk_idx, 4);
    chk("d_groups", g_n, 2);
    chk("d_rd_beats", rd_n, 2048);
    chk("d_ecnt", ecnt, 0);
    run = 1'b0;
    repeat (2) @(negedge clk);

    // run E: ready lost during read
    run = 1'b1;
    for (int i = 0; i < 5000 && !(bus.start && !bus.we); i++) @(negedge clk);
    chk("e_in_read", bus.start && !bus.we, 1);
    repeat (5) @(negedge clk);
    bus.ready = 1'b0;
    @(negedge clk);
    chk("e_fault", fault, 1);
    chk("e_start", bus.start, 0);
    chk("e_busy", busy, 0);
    bus.ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("e_fault_held", fault, 1);
    run = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("e_rst_fault", fault, 0);
    chk("e_rst_idx", bus.blk_idx, 0);
    chk("e_rst_cnt", bus.blk_cnt, 0);
    chk("e_rst_we", bus.we, 0);
    chk("e_rst_busy", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
